// File: rtl/vec_wb_serializer_if.sv
// vec_wb_serializer_if
// Bundles the result-capture handshake and the lane write port of the
// vector write-back serializer.
//   in_valid/in_ready   : result capture handshake
//   in_result           : LANES x LANE_W packed result, lane i at [LANE_W*i +: LANE_W]
//   in_flags            : 4-bit flag nibble per lane, lane i at [4*i +: 4]
//   in_scalar           : result carries lane 0 only
//   in_base_addr        : byte address of lane 0
//   mem_addr/wdata/we   : 16-bit data-memory write port
//   mem_stall           : memory refuses the write this cycle
//   done                : one-cycle pulse when the transfer retires
//   flags_or            : OR of the flag nibbles of the retired lanes
// The slave modport is the serializer; the master modport is its environment
// (upstream ALU stage plus data memory).
interface vec_wb_serializer_if #(
    parameter int LANES  = 16,
    parameter int LANE_W = 16,
    parameter int ADDR_W = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*LANE_W-1:0]   in_result;
    logic [4*LANES-1:0]        in_flags;
    logic                      in_scalar;
    logic [ADDR_W-1:0]         in_base_addr;
    logic [ADDR_W-1:0]         mem_addr;
    logic [LANE_W-1:0]         mem_wdata;
    logic                      mem_we;
    logic                      mem_stall;
    logic                      done;
    logic [3:0]                flags_or;

    modport slave (
        input  in_valid, in_result, in_flags, in_scalar, in_base_addr, mem_stall,
        output in_ready, mem_addr, mem_wdata, mem_we, done, flags_or
    );

    modport master (
        output in_valid, in_result, in_flags, in_scalar, in_base_addr, mem_stall,
        input  in_ready, mem_addr, mem_wdata, mem_we, done, flags_or
    );
endinterface

// File: rtl/vec_wb_serializer.sv
// vec_wb_serializer
// Captures one vector ALU result with its per-lane flags and streams the lanes,
// one per cycle, to a LANE_W-bit data-memory write port under stall
// backpressure. Scalar results write lane 0 only.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : vec_wb_serializer_if.slave (capture handshake, write port, done, flags_or)
// Optional feature:
//   VEC_WB_ZERO_SKIP_EN - lanes equal to zero are presented with mem_we=0 and
//   advance without waiting on mem_stall; their flags are still accumulated.
module vec_wb_serializer #(
    parameter int LANES  = 16,
    parameter int LANE_W = 16,
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    vec_wb_serializer_if.slave bus
);
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_VEC = IDX_W'(LANES - 1);
`ifdef VEC_WB_ZERO_SKIP_EN
    localparam logic SKIP_EN = 1'b1;
`else
    localparam logic SKIP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                    state_r;
    logic [LANES*LANE_W-1:0]   result_r;
    logic [4*LANES-1:0]        flags_r;
    logic [IDX_W-1:0]          idx_r;
    logic [IDX_W-1:0]          last_r;
    logic [3:0]                flag_acc_r;
    logic                      in_ready_r;
    logic [ADDR_W-1:0]         mem_addr_r;
    logic [LANE_W-1:0]         mem_wdata_r;
    logic                      mem_we_r;
    logic                      done_r;
    logic [3:0]                flags_or_r;

    logic [IDX_W-1:0]          next_idx_s;
    logic [LANE_W-1:0]         next_lane_s;
    logic [LANE_W-1:0]         first_lane_s;
    logic [3:0]                cur_nib_s;
    logic                      advance_s;

    function automatic logic [LANE_W-1:0] lane_sel(input logic [LANES*LANE_W-1:0] vec,
                                                   input logic [IDX_W-1:0] i);
        lane_sel = vec[i*LANE_W +: LANE_W];
    endfunction

    function automatic logic [3:0] nib_sel(input logic [4*LANES-1:0] flg,
                                           input logic [IDX_W-1:0] i);
        nib_sel = flg[i*4 +: 4];
    endfunction

    // A lane is strobed unless zero-skip is built in and the lane is zero.
    function automatic logic lane_we(input logic [LANE_W-1:0] v);
        lane_we = !SKIP_EN || (v != {LANE_W{1'b0}});
    endfunction

    // Next-lane selection and lane-acceptance decode for the WRITE state.
    always_comb begin
        next_idx_s   = idx_r + IDX_W'(1);
        next_lane_s  = lane_sel(result_r, next_idx_s);
        first_lane_s = bus.in_result[LANE_W-1:0];
        cur_nib_s    = nib_sel(flags_r, idx_r);
        // A skipped (unstrobed) lane cannot be stalled; a strobed one waits for the memory.
        if (SKIP_EN && !mem_we_r) begin
            advance_s = 1'b1;
        end else begin
            advance_s = !bus.mem_stall;
        end
    end

    // Serializer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            result_r    <= {(LANES*LANE_W){1'b0}};
            flags_r     <= {(4*LANES){1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            last_r      <= {IDX_W{1'b0}};
            flag_acc_r  <= 4'b0000;
            in_ready_r  <= 1'b1;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {LANE_W{1'b0}};
            mem_we_r    <= 1'b0;
            done_r      <= 1'b0;
            flags_or_r  <= 4'b0000;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.in_valid) begin
                        // Lane 0 is presented straight from the inputs so the
                        // first write appears the cycle after capture.
                        result_r    <= bus.in_result;
                        flags_r     <= bus.in_flags;
                        idx_r       <= {IDX_W{1'b0}};
                        last_r      <= bus.in_scalar ? {IDX_W{1'b0}} : LAST_VEC;
                        flag_acc_r  <= 4'b0000;
                        mem_addr_r  <= bus.in_base_addr;
                        mem_wdata_r <= first_lane_s;
                        mem_we_r    <= lane_we(first_lane_s);
                        in_ready_r  <= 1'b0;
                        state_r     <= WRITE;
                    end else begin
                        in_ready_r <= 1'b1;
                        mem_we_r   <= 1'b0;
                        state_r    <= IDLE;
                    end
                end
                WRITE: begin
                    in_ready_r <= 1'b0;
                    if (advance_s) begin
                        if (idx_r == last_r) begin
                            mem_we_r   <= 1'b0;
                            done_r     <= 1'b1;
                            flags_or_r <= flag_acc_r | cur_nib_s;
                            flag_acc_r <= flag_acc_r | cur_nib_s;
                            state_r    <= DONE;
                        end else begin
                            // Address advances even for skipped lanes: it is always base + 2*idx.
                            idx_r       <= next_idx_s;
                            mem_addr_r  <= mem_addr_r + ADDR_W'(2);
                            mem_wdata_r <= next_lane_s;
                            mem_we_r    <= lane_we(next_lane_s);
                            flag_acc_r  <= flag_acc_r | cur_nib_s;
                            state_r     <= WRITE;
                        end
                    end else begin
                        // Stalled: address, data and strobe hold.
                        mem_we_r <= mem_we_r;
                        state_r  <= WRITE;
                    end
                end
                DONE: begin
                    done_r     <= 1'b0;
                    mem_we_r   <= 1'b0;
                    in_ready_r <= 1'b1;
                    state_r    <= IDLE;
                end
                default: begin
                    done_r     <= 1'b0;
                    mem_we_r   <= 1'b0;
                    in_ready_r <= 1'b1;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.done      = done_r;
    assign bus.flags_or  = flags_or_r;
endmodule

// File: doc/vec_wb_serializer.md
# vec_wb_serializer

Write-back serializer on the result side of the vector ALU. It captures one 256-bit ALU result (16 lanes × 16-bit Q8.8) and its 64-bit per-lane flag word through a valid/ready handshake. It then streams the lanes one per cycle to a 16-bit data-memory write port, with stall backpressure. Scalar results write only lane 0.

## Interface
- LANES, 16, number of lanes in a vector result
- LANE_W, 16, lane width in bits (Q8.8)
- ADDR_W, 32, memory byte-address width
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  result/flags/scalar/base_addr are valid
- in_ready  out  1  block can capture a result
- in_result  in  LANES*LANE_W  ALU result; lane i = bits [16i+15:16i]
- in_flags  in  4*LANES  ALU flags; lane i = bits [4i+3:4i]
- in_scalar  in  1  1 = scalar result, lane 0 only
- in_base_addr  in  ADDR_W  byte address of lane 0
- mem_addr  out  ADDR_W  write byte address
- mem_wdata  out  LANE_W  write data
- mem_we  out  1  write strobe
- mem_stall  in  1  memory cannot accept the write this cycle
- done  out  1  one-cycle pulse when all lanes are retired
- flags_or  out  4  OR of flag nibbles of written lanes for the last completed transfer

## Operation
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1 on a clock edge: capture result, flags, scalar and base_addr; set idx=0; set last = scalar ? 0 : LANES-1; go to WRITE.
- WRITE:
  - in_ready=0, mem_we=1, mem_addr = base + 2*idx (ADDR_W wrap, no carry-out), mem_wdata = lane[idx].
  - mem_stall=1: idx, address and data all hold.
  - mem_stall=0 and idx<last: idx increments.
  - mem_stall=0 and idx==last: go to DONE.
  - flag_acc ORs the flag nibble of each lane in the cycle it is accepted.
- DONE:
  - done=1 and flags_or updated from flag_acc; mem_we=0; in_ready=0.
  - Next state is always IDLE. flag_acc clears on the next capture.
- Input is ignored outside IDLE. The upstream stage holds in_valid and its data until in_ready=1.
- A lane is "accepted" when mem_we=1 and mem_stall=0 on the same edge.

## Timing
- Reset values: FSM=IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, done=0, flags_or=0, idx=0.
- Capture edge N: first write is presented in cycle N+1.
- With no stalls:
  - Vector: writes in cycles N+1..N+16, done in cycle N+17, in_ready=1 in cycle N+18.
  - Scalar: write in cycle N+1, done in cycle N+2.
- Each stall cycle adds exactly one cycle. Throughput is at most one transfer per LANES+2 cycles.
- rst in any state: next cycle returns to reset values; the partial transfer is abandoned with no done and flags_or unchanged from reset (0).
- A stall on the final lane delays DONE; done never asserts while mem_we=1.
- Writes are registered; mem_* outputs are driven from flops only.

## Configuration
- VEC_WB_ZERO_SKIP_EN defined:
  - In WRITE, a lane whose value is 0x0000 is presented with mem_we=0 and advances unconditionally, ignoring mem_stall.
  - Its flags are still ORed. Cycle count is identical to the non-skip case when there are no stalls.
- Not defined: every lane is written, including zeros.

## Test plan
- Reset then idle: rst=1 for 2 cycles → in_ready=1, mem_we=0, done=0, flags_or=0.
- Vector write, base 0x1000, lane0=0x0140, lane1=0x0180, lane15=0xFE80, no stall:
  - mem_we=1 for 16 consecutive cycles; addresses 0x1000..0x101E step 2; lane data in order.
  - done pulses exactly 1 cycle after lane 15.
- Scalar write, base 0x2000, lane0=0x0300, other lanes nonzero, in_flags lane0=4'b0010 → single write 0x2000/0x0300, done next cycle, flags_or=4'b0010.
- Stall on lane 5 for 3 cycles → addr 0x100A and its data hold 3 extra cycles; no lane is duplicated or skipped; done at capture+20.
- Flags OR, vector, lane3 flags=4'b0001, lane12 flags=4'b1000, rest 0 → flags_or=4'b1001 at done. in_valid held during WRITE is not recaptured.
- rst asserted at lane 7 → next cycle mem_we=0, in_ready=1, no done. A new transfer then starts cleanly at lane 0.
- With VEC_WB_ZERO_SKIP_EN: lanes 2 and 9 = 0x0000 → mem_we=0 in those two cycles; 14 writes total; done timing unchanged.
